// File: rtl/cla_seq_ctrl.sv
// Purpose: sequences a shared registered 4-bit CLA slice nibble-by-nibble to add/subtract WIDTH-bit operands.
// Latency: start accepted at edge 0 -> done pulses in cycle 2*NIB+1; throughput 2*NIB+2 cycles per op.
// Backpressure: start is ignored while busy (no queueing); the caller retries after busy drops.
module cla_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             cla_en,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [4:0]       cla_q
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Operands are viewed as nibble arrays so the slice can be fed by index.
    logic [NIB-1:0][3:0] a_lat;
    logic [NIB-1:0][3:0] b_lat;    // already inverted for subtraction
    logic [NIB-1:0][3:0] sum_r;
    logic                carry;
    logic [IW-1:0]       idx;
    logic                last_nib;

    assign last_nib = (idx == IW'(NIB - 1));

    // Slice inputs come straight from the latched operands; they are only
    // consumed while cla_en is high, and read as zero after reset.
    assign cla_a   = a_lat[idx];
    assign cla_b   = b_lat[idx];
    assign cla_cin = carry;
    assign sum     = sum_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        cla_en    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cla_en    = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = last_nib ? DONE : ISSUE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, carry chain, nibble index and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat <= '0;
            b_lat <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            idx   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat <= a;
                        b_lat <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        sum_r <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                CAPTURE: begin
                    sum_r[idx] <= cla_q[3:0];
                    carry      <= cla_q[4];
                    if (last_nib) begin
                        // Final nibble: cla_q[3] is the result MSB, so flags
                        // are ready for the DONE cycle.
                        cout <= cla_q[4];
                        ovf  <= (a_lat[NIB-1][3] == b_lat[NIB-1][3]) &&
                                (cla_q[3] != a_lat[NIB-1][3]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_ctrl.sv
module tb_cla_seq_ctrl;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         cla_en;
    logic [3:0]   cla_a;
    logic [3:0]   cla_b;
    logic         cla_cin;
    logic [4:0]   cla_q;

    int n_cmp = 0;
    int n_bad = 0;

    cla_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf),
        .cla_en  (cla_en),
        .cla_a   (cla_a),
        .cla_b   (cla_b),
        .cla_cin (cla_cin),
        .cla_q   (cla_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, sum}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s, input logic c);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   r;
        logic         v;
        yy = s ? ~y : y;
        cc = s ? 1'b1 : c;
        r  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        v  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
        return {v, r};
    endfunction

    // Carry into nibble k = carry out of the low 4*k bits of the full addition.
    function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] yy,
                                        input logic c, input int k);
        logic [31:0] msk;
        logic [31:0] s;
        msk = (32'd1 << (4 * k)) - 32'd1;
        s   = ({16'd0, x} & msk) + ({16'd0, yy} & msk) + {31'd0, c};
        return s[4*k];
    endfunction

    function automatic logic [3:0] nib(input logic [W-1:0] x, input int k);
        logic [W-1:0] t;
        t = x >> (4 * k);
        return t[3:0];
    endfunction

    // Shared CLA slice: registered {cout,sum}, valid one cycle after cla_en.
    initial cla_q = '0;
    always @(posedge clk) begin
        if (cla_en) cla_q <= {1'b0, cla_a} + {1'b0, cla_b} + {4'd0, cla_cin};
    end

    // Behavioural model: m_t counts edges since the accepting edge.
    logic         m_busy;
    int           m_t;
    logic [W-1:0] m_a;
    logic [W-1:0] m_bb;
    logic         m_c;
    logic [W+1:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_t    <= 0;
            m_a    <= '0;
            m_bb   <= '0;
            m_c    <= 1'b0;
            m_res  <= '0;
        end else if (m_busy) begin
            m_t <= m_t + 1;
            if (m_t == 2 * NIB) m_busy <= 1'b0;
        end else if (start) begin
            m_busy <= 1'b1;
            m_t    <= 0;
            m_a    <= a;
            m_bb   <= sub ? ~b : b;
            m_c    <= sub | cin;
            m_res  <= ref_add(a, b, sub, cin);
        end
    end

    // Compare process.
    int         en_cnt   = 0;
    int         ops_done = 0;
    int         mon_k;
    logic [3:0] cin_hist = '0;
    logic       exp_issue;
    logic       exp_done;

    always @(negedge clk) begin
        if (rst_n) begin
            exp_issue = m_busy && (m_t < 2 * NIB) && (m_t % 2 == 0);
            exp_done  = m_busy && (m_t == 2 * NIB);
            chk("busy", busy, m_busy);
            chk("done", done, exp_done);
            chk("cla_en", cla_en, exp_issue);
            if (exp_issue) begin
                mon_k = m_t / 2;
                chk("cla_a", cla_a, nib(m_a, mon_k));
                chk("cla_b", cla_b, nib(m_bb, mon_k));
                chk("cla_cin", cla_cin, carry_into(m_a, m_bb, m_c, mon_k));
            end
            if (m_busy && m_t == 0) en_cnt = int'(cla_en);
            else                    en_cnt = en_cnt + int'(cla_en);
            if (cla_en) cin_hist = {cin_hist[2:0], cla_cin};
            if (!m_busy || exp_done) begin
                chk("sum", sum, m_res[W-1:0]);
                chk("cout", cout, m_res[W]);
                chk("ovf", ovf, m_res[W+1]);
            end
            if (exp_done) begin
                chk("en_per_op", en_cnt, NIB);
                ops_done++;
            end
        end
    end

    // One operation; returns with done visible (just after the done edge).
    task automatic run_op(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic c, input bit noise);
        int lat;
        @(posedge clk); #1;
        start = 1'b1; sub = s; a = aa; b = bb; cin = c;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            if (noise) begin
                start = ($urandom % 4 == 0);
                a     = W'($urandom);
                b     = W'($urandom);
                sub   = 1'($urandom);
                cin   = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        // Accepting edge is edge 0; done is visible after edge 2*NIB.
        chk("latency", lat, 2 * NIB);
    endtask

    int done_seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        #12;
        chk("reset_flags", {busy, done, cout, ovf, cla_en, cla_cin}, 0);
        chk("reset_sum", sum, 0);
        chk("reset_slice", {cla_a, cla_b}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Wrap-around add.
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        chk("t1_sum", sum, 16'h0000);
        chk("t1_cout", cout, 1'b1);
        chk("t1_ovf", ovf, 1'b0);

        // Signed overflow on add; carry ripples into nibbles 1..3.
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        chk("t2_sum", sum, 16'h8000);
        chk("t2_cout", cout, 1'b0);
        chk("t2_ovf", ovf, 1'b1);
        chk("t2_cin_seq", cin_hist, 4'b0111);

        // Subtraction: borrow, then signed overflow.
        run_op(1'b1, 16'h1234, 16'h1235, 1'b0, 1'b0);
        chk("t3a_sum", sum, 16'hFFFF);
        chk("t3a_cout", cout, 1'b0);
        chk("t3a_ovf", ovf, 1'b0);
        run_op(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
        chk("t3b_sum", sum, 16'h7FFF);
        chk("t3b_cout", cout, 1'b1);
        chk("t3b_ovf", ovf, 1'b1);

        // Starts while busy are ignored; the first IDLE-cycle start is taken.
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            @(posedge clk); #1;
            if (e == 2) begin
                start = 1'b1; a = 16'h5555; b = 16'h1111; sub = 1'b1;
            end
            if (e == 3) start = 1'b0;
            if (e == 8) begin
                chk("t4_done1", done, 1'b1);
                chk("t4_sum1", sum, 16'h3333);
                start = 1'b1; sub = 1'b1; a = 16'h0100; b = 16'h0001; cin = 1'b0;
            end
            if (e == 9) chk("t4_ignored_in_done", done, 1'b0);
            if (e == 10) begin
                start = 1'b0;
                chk("t4_accepted", busy, 1'b1);
            end
            if (e == 18) begin
                chk("t4_done2", done, 1'b1);
                chk("t4_sum2", sum, 16'h00FF);
                chk("t4_cout2", cout, 1'b1);
            end
        end

        // Reset in the second CAPTURE cycle aborts the operation.
        @(posedge clk); #1;
        start = 1'b1; sub = 1'b0; a = 16'hABCD; b = 16'h1234; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_flags", {busy, done, cout, ovf, cla_en, cla_cin}, 0);
        chk("t5_sum", sum, 0);
        chk("t5_slice", {cla_a, cla_b}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("t5_no_done", done_seen, 0);
        run_op(1'b0, 16'h00FF, 16'h0F01, 1'b1, 1'b0);
        chk("t5_sum_restart", sum, 16'h1001);
        chk("t5_cout_restart", cout, 1'b0);

        // Random operations with random gaps and ignored mid-op starts.
        for (int i = 0; i < 500; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("op_count", ops_done, 507);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
